mult_sequencer: RTL
===================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter W, default 4, meaning operand width (matches downstream cyclic_multiplier W).
REQ-002 SHALL have parameter DEPTH, default 2, meaning operand FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-007 SHALL have ports in_a, in_b  input  W each  operand pair.
REQ-008 SHALL have port mult_load  output  1  one-cycle start pulse to cyclic_multiplier load.
REQ-009 SHALL have ports mult_a, mult_b  output  W each  registered operands to the multiplier.
REQ-010 SHALL have port mult_p  input  2W  multiplier product.
REQ-011 SHALL have port mult_valid  input  1  multiplier idle/result-valid flag.
REQ-012 SHALL have port out_valid  output  1  result held on out_p.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_p  output  2W  registered product.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port ops_done  output  8  count of results accepted downstream, wraps 255->0.

Function
REQ-017 FIFO push SHALL occur on a rising edge where in_valid && in_ready; in_ready SHALL equal (count < DEPTH); no push-when-full bypass.
REQ-018 FIFO order SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH; count width SHALL hold 0..DEPTH inclusive.
REQ-019 Simultaneous push and pop in one cycle SHALL leave count unchanged and both take effect.
REQ-020 FSM states SHALL be IDLE, LOAD, WAIT_LOW, WAIT_HIGH, OUT.
REQ-021 IDLE: if count>0, SHALL pop head into mult_a/mult_b and go to LOAD; else stay.
REQ-022 LOAD: mult_load SHALL be 1 for exactly this one cycle; next state WAIT_LOW.
REQ-023 WAIT_LOW: stay while mult_valid=1; go to WAIT_HIGH on first cycle mult_valid=0.
REQ-024 WAIT_HIGH: stay while mult_valid=0; on first cycle mult_valid=1 SHALL capture mult_p into out_p and go to OUT.
REQ-025 OUT: out_valid SHALL be 1; on out_ready=1 SHALL increment ops_done and go to IDLE; else hold out_p and stay.
REQ-026 out_valid SHALL be 1 only in OUT; out_p SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 mult_a/mult_b SHALL change only on the IDLE pop and SHALL remain stable through LOAD, WAIT_LOW, WAIT_HIGH.
REQ-028 mult_load SHALL be 0 in every state except LOAD.
REQ-029 FIFO SHALL keep accepting pushes in every FSM state, including OUT stall.
REQ-030 Latency (empty FIFO, out_ready=1, W=4 multiplier): push edge to out_valid SHALL be W+4 cycles, i.e. push, IDLE pop, LOAD, WAIT_LOW, W cycles WAIT_HIGH.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, FIFO count and pointers=0, mult_load=0, mult_a=mult_b=0, out_p=0, out_valid=0, busy=0, ops_done=0, in_ready=1.
REQ-032 Reset mid-operation SHALL discard FIFO contents and any in-flight product; no out_valid SHALL follow without a new push.
REQ-033 First rising edge after rst_n deasserts SHALL be usable for a push.

Verification
REQ-034 W=4, push a=13 b=11, out_ready=1 -> one mult_load pulse, mult_a=13 mult_b=11, out_p=0x8F (143), out_valid one cycle, ops_done=1.
REQ-035 Push (15,15),(0,9),(1,1) back-to-back, out_ready=1 -> results 225, 0, 1 in order, exactly three mult_load pulses, ops_done=3.
REQ-036 out_ready=0, push four pairs (3,4),(5,6),(7,8),(2,2) -> first result 12 held, mult_a=3 held, FIFO holds remaining 3rd-push state: in_ready drops after FIFO reaches DEPTH=2, 4th push stalls until out_ready=1; all four results 12,30,56,4 delivered in order.
REQ-037 Assert rst_n=0 during WAIT_HIGH with two pairs queued -> all outputs to reset values immediately; no result emitted after release.
REQ-038 256 accepted results -> ops_done wraps to 0.
REQ-039 Simultaneous push and pop at count=DEPTH-1 -> count unchanged, data order preserved.

Source files
------------

// File: rtl/mult_sequencer.sv
// Operand FIFO feeding a cyclic multiplier: pairs are queued, issued one at a
// time with a load pulse, and each product is held on out_p until downstream takes it.
module mult_sequencer #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             mult_load,
    output logic [W-1:0]     mult_a,
    output logic [W-1:0]     mult_b,
    input  logic [2*W-1:0]   mult_p,
    input  logic             mult_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             busy,
    output logic [7:0]       ops_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        OUT       = 3'd4
    } state_t;

    state_t         state;
    logic [W-1:0]   fifo_a [DEPTH];
    logic [W-1:0]   fifo_b [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and ready never waits on valid.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE);

    // Storage carries no reset; entries are only read when count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mult_load <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mult_load <= 1'b0;
                    if (pop) begin
                        mult_a    <= fifo_a[rd_ptr];
                        mult_b    <= fifo_b[rd_ptr];
                        mult_load <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    mult_load <= 1'b0;
                    state     <= WAIT_LOW;
                end
                // The multiplier drops mult_valid once it has taken the load.
                WAIT_LOW: begin
                    if (!mult_valid) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (mult_valid) begin
                        out_p     <= mult_p;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mult_load <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
